uart_imem_loader: RTL

Parametrised successor to the single-channel UART byte receiver used for boot-time program loading. It receives 8N1 UART bytes and assembles them into little-endian WORD_BYTES-wide words. Each completed word is written to instruction memory at sequentially incremented addresses. Loading terminates on a sentinel sequence or when memory is full, after which write_done is raised. It sits between the uart_rxd pin and the instruction-memory write port in the processor wrapper.

---
 rtl/uart_loader_pkg.sv | 35 +++
 rtl/uart_loader_rx_core.sv | 131 +++++++++++++
 rtl/uart_imem_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
// Holds the RX and loader state encodings and baud-rate derivation.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  typedef enum logic {
    LOAD,
    DONE
  } ld_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int cyc_per_bit(
    input int clk_hz,
    input int bit_rate
  );
    return clk_hz / bit_rate;
  endfunction

  localparam int CYC_PER_BIT = cyc_per_bit(50000000, 9600);

endpackage

// File: rtl/uart_loader_rx_core.sv
// 8N1 UART receiver: synchroniser, baud counter and RX FSM.
// Emits one-cycle valid/break pulses and a sticky frame error.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CYC_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       break_o,
  output logic       frame_err_o
);

  localparam int CNT_W = clog2(CYC_PER_BIT + 1);
  localparam int HALF = CYC_PER_BIT / 2;
  localparam int HALF_END = (HALF > 0) ? HALF - 1 : 0;
  localparam int BIT_END = CYC_PER_BIT - 1;

  rx_state_e        state_q;
  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             armed_q;
  logic             valid_q;
  logic [7:0]       data_q;
  logic             break_q;
  logic             ferr_q;

  logic half_hit;
  logic bit_hit;

  assign half_hit = (cnt_q == CNT_W'(HALF_END));
  assign bit_hit  = (cnt_q == CNT_W'(BIT_END));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      break_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rxd_i;
      sync_q  <= meta_q;
      valid_q <= 1'b0;
      break_q <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            // After a low stop bit the line must return high first
            if (sync_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= START;
            end
          end
          START: begin
            if (half_hit) begin
              cnt_q <= '0;
              bit_q <= '0;
              if (!sync_q) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (bit_hit) begin
              cnt_q   <= '0;
              shift_q <= {sync_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= STOP;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STOP: begin
            if (bit_hit) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              if (sync_q) begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
              end else begin
                armed_q <= 1'b0;
                if (shift_q == 8'h00) begin
                  break_q <= 1'b1;
                end else begin
                  ferr_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign break_o     = break_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into little-endian words and writes
// them to instruction memory until a sentinel run or memory full.
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BIT_RATE   = 9600,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = clog2(DEPTH),
  parameter logic [WORD_BYTES*8-1:0] END_WORD = '1,
  parameter int END_COUNT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [7:0]              uart_rx_data,
  output logic                    uart_rx_break,
  output logic                    frame_err,
  output logic                    imem_wr_en,
  output logic [ADDR_W-1:0]       imem_wr_addr,
  output logic [WORD_BYTES*8-1:0] imem_wr_data,
  output logic                    write_done,
  output logic                    overflow
);

  localparam int W = WORD_BYTES * 8;
  localparam int CPB = cyc_per_bit(CLK_HZ, BIT_RATE);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       rx_ferr;

  uart_rx_core #(
    .CYC_PER_BIT(CPB)
  ) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxd_i      (uart_rxd),
    .en_i       (uart_rx_en),
    .valid_o    (rx_valid),
    .data_o     (rx_data),
    .break_o    (rx_break),
    .frame_err_o(rx_ferr)
  );

  ld_state_e         state_q;
  logic [3:0]        byte_idx_q;
  logic [3:0]        sent_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [W-1:0]      word_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [W-1:0]      wr_data_q;
  logic              fin_q;
  logic              fin_ovf_q;
  logic              done_q;
  logic              ovf_q;

  logic [W-1:0] word_d;
  logic [3:0]   sent_cnt_d;
  logic         last_byte;
  logic         at_last;

  always_comb begin
    word_d = word_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_idx_q == 4'(i)) begin
        word_d[8*i +: 8] = rx_data;
      end
    end
  end

  assign last_byte  = (byte_idx_q == 4'(WORD_BYTES - 1));
  assign at_last    = (addr_q == ADDR_W'(DEPTH - 1));
  assign sent_cnt_d = (word_d == END_WORD) ?
                      sent_cnt_q + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      byte_idx_q <= '0;
      sent_cnt_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      fin_q      <= 1'b0;
      fin_ovf_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      fin_q     <= 1'b0;
      fin_ovf_q <= 1'b0;
      // Status flags lag the final write strobe by one cycle
      done_q    <= done_q | fin_q;
      ovf_q     <= ovf_q | fin_ovf_q;
      unique case (state_q)
        LOAD: begin
          if (rx_valid) begin
            word_q <= word_d;
            if (last_byte) begin
              byte_idx_q <= '0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= addr_q;
              wr_data_q  <= word_d;
              sent_cnt_q <= sent_cnt_d;
              if (sent_cnt_d == 4'(END_COUNT)) begin
                state_q <= DONE;
                fin_q   <= 1'b1;
              end else if (at_last) begin
                state_q   <= DONE;
                fin_q     <= 1'b1;
                fin_ovf_q <= 1'b1;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end else if (rx_break) begin
            byte_idx_q <= '0;
            sent_cnt_q <= '0;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign uart_rx_valid = rx_valid;
  assign uart_rx_data  = rx_data;
  assign uart_rx_break = rx_break;
  assign frame_err     = rx_ferr;
  assign imem_wr_en    = wr_en_q;
  assign imem_wr_addr  = wr_addr_q;
  assign imem_wr_data  = wr_data_q;
  assign write_done    = done_q;
  assign overflow      = ovf_q;

endmodule
